// File: rtl/int_issue_queue.sv
// Age-ordered integer issue queue: collapsing slot array (slot 0 oldest), CDB wakeup,
// oldest-ready select presented to the integer execution unit and retired on grant.
package int_issue_queue_pkg;
    localparam int IQ_TAG_W = 6;

    typedef struct packed {
        logic                cdb_valid;
        logic                cdb_branch;
        logic [IQ_TAG_W-1:0] cdb_tag;
        logic [31:0]         cdb_result;
    } cdb_bfm;

    typedef struct packed {
        logic [31:0]         rs1_data;
        logic [31:0]         rs2_data;
        logic [IQ_TAG_W-1:0] rd_tag;
        logic                wb_valid;
    } common_data_t;

    typedef struct packed {
        logic [6:0]   opcode;
        logic [2:0]   func3;
        logic [6:0]   func7;
        common_data_t common_data;
    } int_fifo_data;
endpackage

module int_issue_queue
    import int_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = IQ_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             dispatch_en,
    input  logic [6:0]       dispatch_opcode,
    input  logic [2:0]       dispatch_func3,
    input  logic [6:0]       dispatch_func7,
    input  logic [31:0]      dispatch_rs1_data,
    input  logic [TAG_W-1:0] dispatch_rs1_tag,
    input  logic             dispatch_rs1_rdy,
    input  logic [31:0]      dispatch_rs2_data,
    input  logic [TAG_W-1:0] dispatch_rs2_tag,
    input  logic             dispatch_rs2_rdy,
    input  logic [TAG_W-1:0] dispatch_rd_tag,
    input  logic             dispatch_wb_valid,
    input  cdb_bfm           cdb,
    input  logic             issue_granted,
    output logic             queue_full,
    output logic             queue_empty,
    output logic             issue_rdy,
    output int_fifo_data     int_exec_fifo_data
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic [6:0]       opcode;
        logic [2:0]       func3;
        logic [6:0]       func7;
        logic [31:0]      rs1_data;
        logic [TAG_W-1:0] rs1_tag;
        logic             rs1_rdy;
        logic [31:0]      rs2_data;
        logic [TAG_W-1:0] rs2_tag;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rd_tag;
        logic             wb_valid;
    } entry_t;

    entry_t           slot_q [DEPTH];
    entry_t           slot_d [DEPTH];
    entry_t           woken  [DEPTH+1];
    entry_t           new_e;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] widx;
    logic             found;
    logic             wake;
    logic             grant;
    logic             disp;

    assign queue_full  = (count_q == CNT_W'(DEPTH));
    assign queue_empty = (count_q == '0);
    assign wake        = cdb.cdb_valid & ~cdb.cdb_branch;
    assign grant       = issue_granted & found;
    assign disp        = dispatch_en & ~queue_full;
    assign issue_rdy   = found;

    // Oldest ready wins: scan from the top so the lowest index is written last.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_q[i].valid && slot_q[i].rs1_rdy && slot_q[i].rs2_rdy) begin
                sel   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        int_exec_fifo_data = '0;
        if (found) begin
            int_exec_fifo_data.opcode               = slot_q[sel].opcode;
            int_exec_fifo_data.func3                = slot_q[sel].func3;
            int_exec_fifo_data.func7                = slot_q[sel].func7;
            int_exec_fifo_data.common_data.rs1_data = slot_q[sel].rs1_data;
            int_exec_fifo_data.common_data.rs2_data = slot_q[sel].rs2_data;
            int_exec_fifo_data.common_data.rd_tag   = slot_q[sel].rd_tag;
            int_exec_fifo_data.common_data.wb_valid = slot_q[sel].wb_valid;
        end
    end

    // Wakeup is applied before the collapse so a shifting slot still captures the CDB.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = slot_q[i];
            if (slot_q[i].valid && wake) begin
                if (!slot_q[i].rs1_rdy && slot_q[i].rs1_tag == cdb.cdb_tag) begin
                    woken[i].rs1_data = cdb.cdb_result;
                    woken[i].rs1_rdy  = 1'b1;
                end
                if (!slot_q[i].rs2_rdy && slot_q[i].rs2_tag == cdb.cdb_tag) begin
                    woken[i].rs2_data = cdb.cdb_result;
                    woken[i].rs2_rdy  = 1'b1;
                end
            end
        end
        woken[DEPTH] = '0;
    end

    always_comb begin
        new_e          = '0;
        new_e.valid    = 1'b1;
        new_e.opcode   = dispatch_opcode;
        new_e.func3    = dispatch_func3;
        new_e.func7    = dispatch_func7;
        new_e.rs1_data = dispatch_rs1_data;
        new_e.rs1_tag  = dispatch_rs1_tag;
        new_e.rs1_rdy  = dispatch_rs1_rdy;
        new_e.rs2_data = dispatch_rs2_data;
        new_e.rs2_tag  = dispatch_rs2_tag;
        new_e.rs2_rdy  = dispatch_rs2_rdy;
        new_e.rd_tag   = dispatch_rd_tag;
        new_e.wb_valid = dispatch_wb_valid;
        if (wake && !dispatch_rs1_rdy && dispatch_rs1_tag == cdb.cdb_tag) begin
            new_e.rs1_data = cdb.cdb_result;
            new_e.rs1_rdy  = 1'b1;
        end
        if (wake && !dispatch_rs2_rdy && dispatch_rs2_tag == cdb.cdb_tag) begin
            new_e.rs2_data = cdb.cdb_result;
            new_e.rs2_rdy  = 1'b1;
        end
    end

    always_comb begin
        widx    = IDX_W'(count_q - CNT_W'(grant));
        count_d = count_q + CNT_W'(disp) - CNT_W'(grant);
        for (int i = 0; i < DEPTH; i++) begin
            if (grant && i >= int'(sel)) slot_d[i] = woken[i+1];
            else                         slot_d[i] = woken[i];
        end
        if (disp) slot_d[widx] = new_e;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: expected issues are queued at grant time and
// checked by a negedge monitor; status flags are checked inline.
module tb_int_issue_queue;
    import int_issue_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             dispatch_en;
    logic [6:0]       dispatch_opcode;
    logic [2:0]       dispatch_func3;
    logic [6:0]       dispatch_func7;
    logic [31:0]      dispatch_rs1_data;
    logic [TAG_W-1:0] dispatch_rs1_tag;
    logic             dispatch_rs1_rdy;
    logic [31:0]      dispatch_rs2_data;
    logic [TAG_W-1:0] dispatch_rs2_tag;
    logic             dispatch_rs2_rdy;
    logic [TAG_W-1:0] dispatch_rd_tag;
    logic             dispatch_wb_valid;
    cdb_bfm           cdb;
    logic             issue_granted;
    logic             queue_full;
    logic             queue_empty;
    logic             issue_rdy;
    int_fifo_data     int_exec_fifo_data;

    int           checks = 0;
    int           errors = 0;
    int_fifo_data sb[$];
    int_fifo_data mon_e;

    int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .dispatch_en(dispatch_en),
        .dispatch_opcode(dispatch_opcode), .dispatch_func3(dispatch_func3),
        .dispatch_func7(dispatch_func7), .dispatch_rs1_data(dispatch_rs1_data),
        .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs1_rdy(dispatch_rs1_rdy),
        .dispatch_rs2_data(dispatch_rs2_data), .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs2_rdy(dispatch_rs2_rdy), .dispatch_rd_tag(dispatch_rd_tag),
        .dispatch_wb_valid(dispatch_wb_valid), .cdb(cdb), .issue_granted(issue_granted),
        .queue_full(queue_full), .queue_empty(queue_empty), .issue_rdy(issue_rdy),
        .int_exec_fifo_data(int_exec_fifo_data)
    );

    always #5 clk = ~clk;

    function automatic int_fifo_data mk(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [5:0] rd,
                                        input logic wb);
        int_fifo_data e;
        e = '0;
        e.opcode = op; e.func3 = f3; e.func7 = f7;
        e.common_data.rs1_data = r1;
        e.common_data.rs2_data = r2;
        e.common_data.rd_tag   = rd;
        e.common_data.wb_valid = wb;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dispatch_en   = 1'b0;
        issue_granted = 1'b0;
        flush         = 1'b0;
        cdb           = '0;
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] r1d, input logic [5:0] r1t, input logic r1r,
                        input logic [31:0] r2d, input logic [5:0] r2t, input logic r2r,
                        input logic [5:0] rd, input logic wb);
        dispatch_en = 1'b1;
        dispatch_opcode = op; dispatch_func3 = f3; dispatch_func7 = f7;
        dispatch_rs1_data = r1d; dispatch_rs1_tag = r1t; dispatch_rs1_rdy = r1r;
        dispatch_rs2_data = r2d; dispatch_rs2_tag = r2t; dispatch_rs2_rdy = r2r;
        dispatch_rd_tag = rd; dispatch_wb_valid = wb;
    endtask

    task automatic grant_exp(input int_fifo_data e);
        sb.push_back(e);
        issue_granted = 1'b1;
    endtask

    // Every grant consumes one expected issue; the presented entry must match it.
    always @(negedge clk) begin
        if (!rst && issue_granted) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected grant with no expected entry rd=%0d",
                         int_exec_fifo_data.common_data.rd_tag);
            end else begin
                mon_e = sb.pop_front();
                if (!issue_rdy || int_exec_fifo_data !== mon_e) begin
                    errors++;
                    $display("FAIL issue_data rdy=%0b got op=%h f3=%0d f7=%h rs1=%h rs2=%h rd=%0d wb=%0b want op=%h f3=%0d f7=%h rs1=%h rs2=%h rd=%0d wb=%0b",
                        issue_rdy, int_exec_fifo_data.opcode, int_exec_fifo_data.func3,
                        int_exec_fifo_data.func7, int_exec_fifo_data.common_data.rs1_data,
                        int_exec_fifo_data.common_data.rs2_data,
                        int_exec_fifo_data.common_data.rd_tag,
                        int_exec_fifo_data.common_data.wb_valid,
                        mon_e.opcode, mon_e.func3, mon_e.func7, mon_e.common_data.rs1_data,
                        mon_e.common_data.rs2_data, mon_e.common_data.rd_tag,
                        mon_e.common_data.wb_valid);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        idle();
        disp(OP_R, 3'd0, 7'd0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 6'd0, 1'b0);
        dispatch_en = 1'b0;
        repeat (2) tick();
        chk("reset_full", 64'(queue_full), 64'd0);
        chk("reset_empty", 64'(queue_empty), 64'd1);
        chk("reset_issue_rdy", 64'(issue_rdy), 64'd0);
        chk("reset_data", 64'(int_exec_fifo_data == '0), 64'd1);
        rst = 1'b0;
        tick();

        // Single ADD, both operands ready: presented one cycle after dispatch.
        disp(OP_R, 3'd0, 7'd0, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 6'd3, 1'b1);
        tick(); idle();
        chk("add_issue_rdy", 64'(issue_rdy), 64'd1);
        chk("add_not_empty", 64'(queue_empty), 64'd0);
        grant_exp(mk(OP_R, 3'd0, 7'd0, 32'd5, 32'd7, 6'd3, 1'b1));
        tick(); idle();
        chk("add_empty_after_grant", 64'(queue_empty), 64'd1);
        chk("add_rdy_after_grant", 64'(issue_rdy), 64'd0);

        // A waits on tag 9, B ready: B first, CDB wakes A during B's grant.
        disp(OP_I, 3'd0, 7'd0, 32'd0, 6'd9, 1'b0, 32'h20, 6'd0, 1'b1, 6'd4, 1'b1);
        tick();
        disp(OP_R, 3'd0, 7'd0, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd5, 1'b1);
        tick(); idle();
        chk("ooo_rdy", 64'(issue_rdy), 64'd1);
        chk("ooo_b_first", 64'(int_exec_fifo_data.common_data.rd_tag), 64'd5);
        cdb = '{cdb_valid: 1'b1, cdb_branch: 1'b0, cdb_tag: 6'd9, cdb_result: 32'h10};
        grant_exp(mk(OP_R, 3'd0, 7'd0, 32'd1, 32'd2, 6'd5, 1'b1));
        tick(); idle();
        chk("ooo_a_woken", 64'(issue_rdy), 64'd1);
        grant_exp(mk(OP_I, 3'd0, 7'd0, 32'h10, 32'h20, 6'd4, 1'b1));
        tick(); idle();
        chk("ooo_empty", 64'(queue_empty), 64'd1);

        // Fill to DEPTH; a dispatch while full is dropped even with a concurrent grant.
        for (int k = 0; k < DEPTH; k++) begin
            disp(OP_R, 3'd0, 7'h20, 32'(100 + k), 6'd0, 1'b1, 32'(k), 6'd0, 1'b1,
                 6'(10 + k), 1'b1);
            tick();
        end
        idle();
        chk("fill_full", 64'(queue_full), 64'd1);
        disp(OP_R, 3'd0, 7'h20, 32'd104, 6'd0, 1'b1, 32'd4, 6'd0, 1'b1, 6'd14, 1'b1);
        grant_exp(mk(OP_R, 3'd0, 7'h20, 32'd100, 32'd0, 6'd10, 1'b1));
        tick(); idle();
        chk("drop_not_full", 64'(queue_full), 64'd0);
        chk("drop_not_empty", 64'(queue_empty), 64'd0);
        for (int k = 1; k < DEPTH; k++) begin
            grant_exp(mk(OP_R, 3'd0, 7'h20, 32'(100 + k), 32'(k), 6'(10 + k), 1'b1));
            tick();
        end
        idle();
        chk("drop_drained", 64'(queue_empty), 64'd1);

        // Dispatch bypass on rs2, then branch CDB must not wake, then real wake.
        disp(OP_R, 3'd7, 7'd0, 32'h1, 6'd0, 1'b1, 32'd0, 6'd4, 1'b0, 6'd20, 1'b1);
        cdb = '{cdb_valid: 1'b1, cdb_branch: 1'b0, cdb_tag: 6'd4, cdb_result: 32'hAB};
        tick(); idle();
        chk("bypass_rdy", 64'(issue_rdy), 64'd1);
        disp(OP_BR, 3'd1, 7'd0, 32'd0, 6'd4, 1'b0, 32'h3, 6'd0, 1'b1, 6'd21, 1'b0);
        tick(); idle();
        cdb = '{cdb_valid: 1'b1, cdb_branch: 1'b1, cdb_tag: 6'd4, cdb_result: 32'h99};
        grant_exp(mk(OP_R, 3'd7, 7'd0, 32'h1, 32'hAB, 6'd20, 1'b1));
        tick(); idle();
        chk("branch_no_wake", 64'(issue_rdy), 64'd0);
        cdb = '{cdb_valid: 1'b1, cdb_branch: 1'b0, cdb_tag: 6'd4, cdb_result: 32'h55};
        #1;
        chk("no_same_cycle_issue", 64'(issue_rdy), 64'd0);
        tick(); idle();
        chk("wake_next_cycle", 64'(issue_rdy), 64'd1);
        grant_exp(mk(OP_BR, 3'd1, 7'd0, 32'h55, 32'h3, 6'd21, 1'b0));
        tick(); idle();
        chk("wake_empty", 64'(queue_empty), 64'd1);

        // Flush beats concurrent dispatch and grant.
        for (int k = 0; k < 3; k++) begin
            disp(OP_R, 3'd0, 7'd0, 32'(k), 6'd0, 1'b1, 32'(k), 6'd0, 1'b1, 6'(30 + k), 1'b1);
            tick();
        end
        idle();
        flush = 1'b1;
        disp(OP_R, 3'd0, 7'd0, 32'd9, 6'd0, 1'b1, 32'd9, 6'd0, 1'b1, 6'd33, 1'b1);
        grant_exp(mk(OP_R, 3'd0, 7'd0, 32'd0, 32'd0, 6'd30, 1'b1));
        tick(); idle();
        chk("flush_empty", 64'(queue_empty), 64'd1);
        chk("flush_issue_rdy", 64'(issue_rdy), 64'd0);
        chk("flush_full", 64'(queue_full), 64'd0);
        tick();
        chk("flush_stays_empty", 64'(queue_empty), 64'd1);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        for (int k = 0; k < 2; k++) begin
            disp(OP_R, 3'd0, 7'd0, 32'(k + 1), 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 6'(40 + k), 1'b1);
            tick();
        end
        idle();
        chk("pre_rst_rdy", 64'(issue_rdy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rdy", 64'(issue_rdy), 64'd0);
        chk("async_rst_empty", 64'(queue_empty), 64'd1);
        chk("async_rst_data", 64'(int_exec_fifo_data == '0), 64'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_empty", 64'(queue_empty), 64'd1);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Age-ordered integer issue queue, sitting between dispatch and the integer execution unit; it is the producer side of the issue_granted / int_fifo_data interface.
- Holds up to DEPTH dispatched integer ops (R, I, LUI, BRANCH).
- Snoops the CDB to wake operands that are waiting on a tag.
- Presents the oldest fully-ready entry to the execution unit and retires it on grant.

Parameters:
- DEPTH, 4, number of queue entries (2..8).
- TAG_W, 6, width of the ROB/rename tag carried in rd_tag, rs*_tag and cdb_tag.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all entries.
- dispatch_en  in  1  write one new entry this cycle.
- dispatch_opcode  in  7  instruction opcode.
- dispatch_func3  in  3  func3 field.
- dispatch_func7  in  7  func7 field.
- dispatch_rs1_data  in  32  rs1 value; valid only when dispatch_rs1_rdy=1.
- dispatch_rs1_tag  in  TAG_W  producer tag for rs1 when not ready.
- dispatch_rs1_rdy  in  1  rs1 value present.
- dispatch_rs2_data  in  32  rs2 value or immediate.
- dispatch_rs2_tag  in  TAG_W  producer tag for rs2.
- dispatch_rs2_rdy  in  1  rs2 value present.
- dispatch_rd_tag  in  TAG_W  destination tag.
- dispatch_wb_valid  in  1  op writes a register.
- cdb  in  cdb_bfm  CDB broadcast; fields used: cdb_valid, cdb_branch, cdb_tag, cdb_result.
- issue_granted  in  1  execution unit consumes the presented entry this cycle.
- queue_full  out  1  count==DEPTH.
- queue_empty  out  1  count==0.
- issue_rdy  out  1  at least one entry has both operands ready.
- int_exec_fifo_data  out  int_fifo_data  oldest ready entry: opcode, func3, func7, common_data.{rs1_data, rs2_data, rd_tag, wb_valid}.

Behaviour:
- Storage: collapsing array with slot 0 oldest. Each slot holds valid, opcode, func3, func7, rs1/rs2 data+tag+rdy, rd_tag, wb_valid. count = number of valid slots; valid slots are always contiguous from 0.
- Reset (async, rst=1): all valid, rdy, data, tags and count cleared. Outputs: queue_full=0, queue_empty=1, issue_rdy=0, int_exec_fifo_data all zeros.
- Select (combinational): sel = lowest-index valid slot with rs1_rdy & rs2_rdy.
  - issue_rdy=1 if such a slot exists; int_exec_fifo_data = slot[sel].
  - Otherwise issue_rdy=0 and int_exec_fifo_data all zeros.
- Grant: issue_granted with issue_rdy=1 removes slot[sel] at the edge; slots above sel shift down one. issue_granted with issue_rdy=0 is ignored.
- Dispatch: dispatch_en & !queue_full writes the new entry at index count, or count-1 if a grant retires an entry the same cycle. dispatch_en while queue_full (pre-edge value) is dropped, even if a grant occurs the same cycle. Dispatch must honour queue_full.
- Wakeup: condition is cdb.cdb_valid & !cdb.cdb_branch. For every valid slot with rsX_rdy=0 and rsX_tag==cdb.cdb_tag: rsX_data<=cdb_result, rsX_rdy<=1. Applies to both operands independently and to slots being shifted this cycle.
- Same-cycle dispatch bypass: if a dispatched operand is not ready and its tag matches a waking CDB broadcast, the entry is written with that operand ready and the cdb_result captured.
- No same-cycle wakeup-to-issue: a slot woken at edge N is selectable from cycle N+1. issue_rdy and data are computed from registered state only.
- Latency: minimum dispatch-to-issue_rdy is 1 cycle (operands ready at dispatch).
- Flush: synchronous, highest priority. At the edge, all slots are invalidated and count=0. Concurrent dispatch, grant and wakeup are discarded.
- Count arithmetic: count_next = count + dispatch_accepted - grant_accepted. Never exceeds DEPTH and never underflows.

Test Plan:
- Reset then dispatch ADD (opcode R_TYPE, func3 0, func7 0, rs1=5, rs2=7, both rdy, rd_tag 3) -> next cycle issue_rdy=1, out rs1_data=5, rs2_data=7, rd_tag=3. Grant -> queue_empty=1 the cycle after.
- Dispatch A (rs1 waiting on tag 9), then B (both ready) -> B is presented first. CDB {valid=1, branch=0, tag=9, result=0x10} -> A's rs1_data=0x10 and A is selectable the next cycle; after B is granted, A is presented.
- Fill 4 entries -> queue_full=1. 5th dispatch with simultaneous grant -> dropped; count=3 after the edge.
- Dispatch with rs2 tag 4 in the same cycle as CDB tag 4 result 0xAB -> entry stored ready with rs2_data=0xAB. CDB with cdb_branch=1, tag 4 -> no wakeup.
- 3 entries queued, flush with concurrent dispatch_en and grant -> queue_empty=1, issue_rdy=0 next cycle.
- Assert rst asynchronously mid-cycle with 2 ready entries -> outputs zero immediately, before the next clock edge.
